seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 13 +
 rtl/seg_scan_ctrl_bcd7seg.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_GUARD,
        ST_SHOW,
        ST_COPY
    } state_t;

    localparam logic [6:0] SEG_DARK = 7'h7F;
    localparam int         NDIG_MAX = 8;

endpackage

// File: rtl/seg_scan_ctrl_bcd7seg.sv
// Hex-to-seven-segment glyph decoder, active-low segments {g,f,e,d,c,b,a}.
// Output is forced dark whenever en is low.
module seg_scan_ctrl_bcd7seg
    import seg_scan_ctrl_pkg::*;
(
    input  logic       en,
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DARK;
        if (en) begin
            case (nibble)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                4'hF: seg = 7'h0E;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with double-buffered digit storage and guard blanking.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NDIG  = 8,
    parameter int SLOT  = 1000,
    parameter int GUARD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_idx,
    input  logic [3:0]      wr_data,
    input  logic [NDIG-1:0] en_mask,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            frame_done
);

    localparam int             CW         = $clog2(SLOT);
    localparam logic [CW-1:0]  GUARD_LAST = CW'(GUARD - 1);
    localparam logic [CW-1:0]  SHOW_LAST  = CW'(SLOT - GUARD - 1);
    localparam logic [2:0]     CUR_LAST   = 3'(NDIG - 1);

    state_t          state, state_next;
    logic [2:0]      cur, cur_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic            copy;
    logic            show;
    logic            wr_ok;
    logic            lzb_blank;
    logic [6:0]      dec_seg;
    logic [6:0]      seg_next;
    logic [NDIG-1:0] an_next;

    logic [3:0] shadow [NDIG_MAX];
    logic [3:0] active [NDIG_MAX];

    // Sequencing: guard -> show per digit, one copy cycle closing each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_GUARD;
            cur   <= 3'd0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cur   <= cur_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cur_next   = cur;
        cnt_next   = cnt + CW'(1);
        copy       = 1'b0;
        case (state)
            ST_GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    cnt_next = '0;
                    if (cur == CUR_LAST) begin
                        state_next = ST_COPY;
                    end else begin
                        state_next = ST_GUARD;
                        cur_next   = cur + 3'd1;
                    end
                end
            end
            ST_COPY: begin
                state_next = ST_GUARD;
                cur_next   = 3'd0;
                cnt_next   = '0;
                copy       = 1'b1;
            end
            default: begin
                state_next = ST_GUARD;
                cur_next   = 3'd0;
                cnt_next   = '0;
            end
        endcase
    end

    // Digit storage: writes go to shadow, active only changes in the copy cycle
    assign wr_ok = wr_valid && wr_ready && (32'(wr_idx) < NDIG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '{default: 4'h0};
            active <= '{default: 4'h0};
        end else begin
            if (wr_ok) begin
                shadow[wr_idx] <= wr_data;
            end
            if (copy) begin
                active <= shadow;
            end
        end
    end

    assign show = (state == ST_SHOW);

    seg_scan_ctrl_bcd7seg u_bcd7seg (
        .en     (show),
        .nibble (active[cur]),
        .seg    (dec_seg)
    );

`ifdef SEG_LZB_EN
    // Dark when this digit and every more significant one hold zero
    always_comb begin
        lzb_blank = (cur != 3'd0);
        for (int i = 0; i < NDIG; i++) begin
            if (3'(i) >= cur && active[i] != 4'h0) begin
                lzb_blank = 1'b0;
            end
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    always_comb begin
        seg_next = lzb_blank ? SEG_DARK : dec_seg;
        an_next  = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (show && en_mask[i] && cur == 3'(i)) begin
                an_next[i] = 1'b0;
            end
        end
    end

    // Output registers: display lags state by one cycle, handshake tracks next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_DARK;
            an         <= '1;
            wr_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            wr_ready   <= (state_next != ST_COPY);
            frame_done <= (state_next == ST_COPY);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, SLOT=10, GUARD=2); expectations
// follow SEG_LZB_EN when the bench is built with that macro.
module tb_seg_scan_ctrl;

    localparam int NDIG   = 4;
    localparam int SLOT   = 10;
    localparam int GUARD  = 2;
    localparam int PERIOD = NDIG * SLOT + 1;

`ifdef SEG_LZB_EN
    localparam logic [6:0] ZD = 7'h7F;
`else
    localparam logic [6:0] ZD = 7'h40;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [2:0]      wr_idx = 3'd0;
    logic [3:0]      wr_data = 4'h0;
    logic [NDIG-1:0] en_mask = 4'hF;
    logic [6:0]      seg;
    logic [NDIG-1:0] an;
    logic            frame_done;

    seg_scan_ctrl #(.NDIG(NDIG), .SLOT(SLOT), .GUARD(GUARD)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .en_mask    (en_mask),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         frame;
        int         dig;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    typedef struct packed {
        logic [15:0] data;   // nibble d at [4d+3:4d]
        logic [3:0]  mask;
        logic [27:0] segs;   // glyph d at [7d+6:7d]
    } vec_t;

    exp_t q[$];
    vec_t vecs [5];

    int   checks = 0;
    int   passes = 0;
    int   cyc;
    int   bad_cnt = 0;
    logic run = 1'b0;
    logic [NDIG-1:0] mask_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) mask_q <= en_mask;

    // Frame-position monitor and scoreboard consumer
    int   fr, pos, sd;
    exp_t e_m;
    always @(negedge clk) begin
        if (run) begin
            fr  = cyc / PERIOD;
            pos = cyc % PERIOD;
            if (pos == PERIOD - 1) begin
                check("frame_done_copy", frame_done, 1);
                check("wr_ready_copy", wr_ready, 0);
            end
            if ((pos == 0 && cyc > 0) || pos == PERIOD - 2) begin
                check("frame_done_idle", frame_done, 0);
                check("wr_ready_idle", wr_ready, 1);
            end
            if (pos == 0 && cyc > 0) check("an_after_copy", an, 4'hF);
            if (pos < PERIOD - 1 && pos % SLOT == GUARD) begin
                check("guard_an", an, 4'hF);
                check("guard_seg", seg, 7'h7F);
            end
            if (pos < PERIOD - 1 && pos % SLOT == 6) begin
                sd = pos / SLOT;
                while (q.size() > 0 && (q[0].frame < fr || (q[0].frame == fr && q[0].dig < sd))) begin
                    check("slot_missed", q[0].frame * 10 + q[0].dig, fr * 10 + sd);
                    void'(q.pop_front());
                end
                if (q.size() > 0 && q[0].frame == fr && q[0].dig == sd) begin
                    e_m = q.pop_front();
                    check($sformatf("an_f%0d_d%0d", fr, sd), an, e_m.an);
                    check($sformatf("seg_f%0d_d%0d", fr, sd), seg, e_m.seg);
                end
            end
            if ((~an & ~mask_q) != 4'h0) bad_cnt++;
        end
    end

    task automatic push(input int f, input int d, input logic [3:0] a, input logic [6:0] s);
        exp_t e;
        e.frame = f; e.dig = d; e.an = a; e.seg = s;
        q.push_back(e);
    endtask

    task automatic write(input logic [2:0] idx, input logic [3:0] d, output int acc, output int waits);
        waits = 0;
        wr_valid = 1'b1; wr_idx = idx; wr_data = d;
        while (wr_ready !== 1'b1 && waits < 8) begin
            @(negedge clk);
            waits++;
        end
        if (wr_ready !== 1'b1) fail_now("write_ready");
        @(negedge clk);
        acc = cyc;
        wr_valid = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc % PERIOD != p && n < 3 * PERIOD);
        if (cyc % PERIOD != p) fail_now("wait_pos");
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) fail_now("scoreboard_drain");
    endtask

    initial begin
        int acc, waits, f;

        vecs[0] = {16'h4321, 4'hF, 7'h19, 7'h30, 7'h24, 7'h79};
        vecs[1] = {16'hDCBA, 4'hF, 7'h21, 7'h46, 7'h03, 7'h08};
        vecs[2] = {16'h98FE, 4'b0101, 7'h10, 7'h00, 7'h0E, 7'h06};
        vecs[3] = {16'h0030, 4'hF, ZD, ZD, 7'h30, 7'h40};
        vecs[4] = {16'h1765, 4'h0, 7'h79, 7'h78, 7'h02, 7'h12};

        // Reset state and release timing
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        check("rel_wr_ready", wr_ready, 1);
        check("rel_an_c1", an, 4'hF);
        @(negedge clk);
        check("rel_an_c2", an, 4'hF);
        @(negedge clk);
        check("rel_an_c3", an, 4'hE);
        check("rel_seg_c3", seg, 7'h40);

        // Mid-frame write of idx2=5: old value this frame, new one next frame
        push(0, 2, 4'hB, ZD);
        wait_pos(14);
        write(3'd2, 4'h5, acc, waits);
        f = (acc - 1) / PERIOD + 1;
        check("midframe_frame", f, 1);
        push(f, 0, 4'hE, 7'h40);
        push(f, 1, 4'hD, 7'h40);
        push(f, 2, 4'hB, 7'h12);
        push(f, 3, 4'h7, ZD);
        drain();

        // Write held across the copy cycle
        wait_pos(PERIOD - 1);
        write(3'd1, 4'h7, acc, waits);
        check("copy_ready_waits", waits, 1);
        f = (acc - 1) / PERIOD + 1;
        push(f - 1, 1, 4'hD, 7'h40);
        push(f, 0, 4'hE, 7'h40);
        push(f, 1, 4'hD, 7'h78);
        push(f, 2, 4'hB, 7'h12);
        push(f, 3, 4'h7, ZD);
        drain();

        // Table vectors: full digit sets under various masks
        for (int v = 0; v < 5; v++) begin
            wait_pos(0);
            en_mask = vecs[v].mask;
            for (int d = 0; d < NDIG; d++) write(3'(d), vecs[v].data[4*d +: 4], acc, waits);
            write(3'd4, 4'h8, acc, waits);
            f = (acc - 1) / PERIOD + 1;
            for (int d = 0; d < NDIG; d++)
                push(f, d, vecs[v].mask[d] ? ~(4'b0001 << d) : 4'hF, vecs[v].segs[7*d +: 7]);
            drain();
        end
        check("an_low_on_masked_digit", bad_cnt, 0);

        // Reset during SHOW of digit 2 with a pending shadow write
        en_mask = 4'hF;
        wait_pos(0);
        write(3'd0, 4'h9, acc, waits);
        wait_pos(25);
        run = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_wr_ready", wr_ready, 0);
        @(negedge clk);
        q.delete();
        rst = 1'b0;
        run = 1'b1;
        for (int fi = 0; fi < 2; fi++) begin
            push(fi, 0, 4'hE, 7'h40);
            push(fi, 1, 4'hD, ZD);
            push(fi, 2, 4'hB, ZD);
            push(fi, 3, 4'h7, ZD);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
